btn_event: RTL and testbench

Button event classifier placed directly downstream of the button debouncer. It takes the debounced, clock-synchronous button level and converts it into single-cycle event pulses for the game controller: press, release, short click, long press and auto-repeat while held. All event outputs are registered, one clock wide, and mutually consistent so the Nim game FSM can consume them without any further edge detection.

---
 rtl/btn_event.sv | 126 ++++++++++++
 tb/tb_btn_event.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// btn_event: turns the debounced button level into one-cycle event pulses.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   level          debounced button level, 1 = pressed
//   held           high while the button is in a pressed state
//   press          pulse on an accepted press
//   release_pulse  pulse on release from a pressed state
//   click          pulse on release before the long threshold (with release_pulse)
//   long_press     pulse when the hold reaches LONG_CYCLES
//   repeat_pulse   pulse every REPEAT_CYCLES while in the long-hold state
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOW  | after reset; ignore the button until it is seen released
// IDLE      | released, waiting for a press
// PRESSED   | held, shorter than LONG_CYCLES so far
// LONG      | held past LONG_CYCLES, auto-repeat running
module btn_event #(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 15_000_000,
   parameter bit REPEAT_EN     = 1'b1,
   parameter int CTR_W         = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic held,
   output logic press,
   output logic release_pulse,
   output logic click,
   output logic long_press,
   output logic repeat_pulse
);

   typedef enum logic [1:0] {
      S_WAIT_LOW = 2'd0,
      S_IDLE     = 2'd1,
      S_PRESSED  = 2'd2,
      S_LONG     = 2'd3
   } state_t;

   // Terminal-count values; the counter starts at 0 so the threshold is N-1.
   localparam logic [CTR_W-1:0] LONG_TC   = CTR_W'(LONG_CYCLES - 1);
   localparam logic [CTR_W-1:0] REPEAT_TC = CTR_W'(REPEAT_CYCLES - 1);

   state_t           state, state_nx;
   logic [CTR_W-1:0] ctr, ctr_nx;
   logic             held_nx, press_nx, release_nx, click_nx, long_nx, repeat_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_WAIT_LOW;
         ctr           <= '0;
         held          <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         click         <= 1'b0;
         long_press    <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         state         <= state_nx;
         ctr           <= ctr_nx;
         held          <= held_nx;
         press         <= press_nx;
         release_pulse <= release_nx;
         click         <= click_nx;
         long_press    <= long_nx;
         repeat_pulse  <= repeat_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      ctr_nx     = ctr;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      click_nx   = 1'b0;
      long_nx    = 1'b0;
      repeat_nx  = 1'b0;
      case (state)
         S_WAIT_LOW: begin
            if (!level) state_nx = S_IDLE;
         end
         S_IDLE: begin
            if (level) begin
               state_nx = S_PRESSED;
               ctr_nx   = '0;
               press_nx = 1'b1;
            end
         end
         S_PRESSED: begin
            // Release is tested first so it wins over the long threshold.
            if (!level) begin
               state_nx   = S_IDLE;
               release_nx = 1'b1;
               click_nx   = 1'b1;
            end else if (ctr == LONG_TC) begin
               state_nx = S_LONG;
               ctr_nx   = '0;
               long_nx  = 1'b1;
            end else begin
               ctr_nx = ctr + 1'b1;
            end
         end
         S_LONG: begin
            if (!level) begin
               state_nx   = S_IDLE;
               release_nx = 1'b1;
            end else if (ctr == REPEAT_TC) begin
               ctr_nx    = '0;
               repeat_nx = REPEAT_EN;
            end else begin
               ctr_nx = ctr + 1'b1;
            end
         end
         default: begin
            state_nx = S_WAIT_LOW;
            ctr_nx   = '0;
         end
      endcase
      held_nx = (state_nx == S_PRESSED) || (state_nx == S_LONG);
   end

endmodule

// File: tb/tb_btn_event.sv
module tb_btn_event;

   localparam int L = 8;
   localparam int R = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic level;

   logic held, press, rel, click, lng, rep;
   logic held0, press0, rel0, click0, lng0, rep0;

   always #5 clk = ~clk;

   btn_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1), .CTR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .level(level),
      .held(held), .press(press), .release_pulse(rel), .click(click),
      .long_press(lng), .repeat_pulse(rep)
   );

   btn_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0), .CTR_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .level(level),
      .held(held0), .press(press0), .release_pulse(rel0), .click(click0),
      .long_press(lng0), .repeat_pulse(rep0)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: hold length h counts consecutive 1 samples of an
   // accepted press; events are simple functions of h.
   int   m_h;
   logic m_armed;
   logic e_held, e_press, e_rel, e_click, e_long, e_rep;

   always @(posedge clk or negedge rst_n) begin
      int h;
      if (!rst_n) begin
         m_h <= 0; m_armed <= 1'b0;
         e_held <= 0; e_press <= 0; e_rel <= 0; e_click <= 0; e_long <= 0; e_rep <= 0;
      end else begin
         e_press <= 0; e_rel <= 0; e_click <= 0; e_long <= 0; e_rep <= 0;
         if (!m_armed) begin
            if (!level) m_armed <= 1'b1;
         end else if (level) begin
            h = m_h + 1;
            m_h     <= h;
            e_held  <= 1'b1;
            e_press <= (h == 1);
            e_long  <= (h == L + 1);
            e_rep   <= (h > L + 1) && (((h - L - 1) % R) == 0);
         end else begin
            if (m_h > 0) begin
               e_rel   <= 1'b1;
               e_click <= (m_h <= L);
            end
            m_h    <= 0;
            e_held <= 1'b0;
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_press = 0, n_rel = 0, n_click = 0, n_long = 0, n_rep = 0, n_held = 0;
   int n_long0 = 0, n_rep0 = 0;
   int at_press = -1, at_rel = -1, at_click = -1, at_long = -1, at_rep = -1, at_long0 = -1;

   always @(negedge clk) begin
      check("held", held, e_held);
      check("press", press, e_press);
      check("release", rel, e_rel);
      check("click", click, e_click);
      check("long", lng, e_long);
      check("repeat", rep, e_rep);
      check("held_r0", held0, e_held);
      check("press_r0", press0, e_press);
      check("release_r0", rel0, e_rel);
      check("click_r0", click0, e_click);
      check("long_r0", lng0, e_long);
      check("repeat_r0", rep0, 0);
      if (press) begin n_press <= n_press + 1; at_press <= cyc; end
      if (rel)   begin n_rel   <= n_rel + 1;   at_rel   <= cyc; end
      if (click) begin n_click <= n_click + 1; at_click <= cyc; end
      if (lng)   begin n_long  <= n_long + 1;  at_long  <= cyc; end
      if (rep)   begin n_rep   <= n_rep + 1;   at_rep   <= cyc; end
      if (held)  n_held <= n_held + 1;
      if (lng0)  begin n_long0 <= n_long0 + 1; at_long0 <= cyc; end
      if (rep0)  n_rep0 <= n_rep0 + 1;
   end

   int base;

   // Drive level 1 on relative edges lo..hi, 0 otherwise, for n edges.
   // Starts and ends just after a falling clock edge.
   task automatic run(input int n, input int lo, input int hi);
      base = cyc;
      for (int j = 1; j <= n; j++) begin
         level = (j >= lo) && (j <= hi);
         @(negedge clk);
      end
      #1;
   endtask

   initial begin
      int p, r, c, lg, rp, hd, lg0;
      level = 1'b0;
      rst_n = 1'b0;
      #1;
      check("reset_held", held, 0);
      check("reset_press", press, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Short click
      p = n_press; r = n_rel; c = n_click; lg = n_long; hd = n_held;
      run(20, 10, 14);
      check("click_press_cnt", n_press - p, 1);
      check("click_press_at", at_press - base, 10);
      check("click_rel_cnt", n_rel - r, 1);
      check("click_rel_at", at_rel - base, 15);
      check("click_click_cnt", n_click - c, 1);
      check("click_click_at", at_click - base, 15);
      check("click_held_cycles", n_held - hd, 5);
      check("click_long_cnt", n_long - lg, 0);

      // Long hold with repeats
      p = n_press; r = n_rel; c = n_click; lg = n_long; rp = n_rep; lg0 = n_long0;
      run(36, 10, 30);
      check("long_press_at", at_press - base, 10);
      check("long_long_cnt", n_long - lg, 1);
      check("long_long_at", at_long - base, 18);
      check("long_rep_cnt", n_rep - rp, 3);
      check("long_rep_last_at", at_rep - base, 30);
      check("long_rel_cnt", n_rel - r, 1);
      check("long_rel_at", at_rel - base, 31);
      check("long_click_cnt", n_click - c, 0);
      check("r0_long_cnt", n_long0 - lg0, 1);
      check("r0_long_at", at_long0 - base, 18);

      // Release at the long threshold
      c = n_click; lg = n_long; r = n_rel;
      run(24, 10, 17);
      check("thr_click_cnt", n_click - c, 1);
      check("thr_click_at", at_click - base, 18);
      check("thr_rel_at", at_rel - base, 18);
      check("thr_long_cnt", n_long - lg, 0);

      // Held through reset
      level = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      p = n_press; hd = n_held;
      run(20, 1, 20);
      check("hr_press_cnt", n_press - p, 0);
      check("hr_held_cycles", n_held - hd, 0);
      p = n_press;
      run(6, 3, 6);
      check("hr_repress_cnt", n_press - p, 1);
      check("hr_repress_at", at_press - base, 3);
      run(3, 0, 0);

      // Reset mid-hold, just after a repeat pulse
      run(22, 10, 22);
      check("mid_rep_before", rep, 1);
      check("mid_held_before", held, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_held_rst", held, 0);
      check("mid_rep_rst", rep, 0);
      check("mid_held0_rst", held0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      p = n_press; hd = n_held;
      run(6, 1, 6);
      check("mid_press_cnt", n_press - p, 0);
      check("mid_held_cycles", n_held - hd, 0);
      p = n_press;
      run(6, 3, 6);
      check("mid_repress_cnt", n_press - p, 1);
      check("mid_repress_at", at_press - base, 3);
      run(4, 0, 0);

      check("r0_rep_total", n_rep0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
